// File: rtl/pattern_serializer_pkg.sv
// Shared FSM encoding and sizing helpers for the serial pattern transmitter.
// Purely declarative: no logic, no latency, no flow control of its own.
package pattern_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit-position counter width for a word of the given width (never below 1).
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out word register; exposes the bit that follows the head.
// Load has priority over shift; no backpressure, one update per enabled cycle.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             next_bit_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The head bit is already in the output flop, so the serializer needs the one after it.
  assign next_bit_o = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];

endmodule

// File: rtl/pattern_serializer.sv
// Serializes an accepted word onto x, repeated in_reps+1 times, first bit 1 cycle after accept.
// in_ready only in IDLE; words offered while busy are ignored; done pulses 1 cycle after last bit.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int REP_W      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_reps,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               sr_load, sr_shift;
  logic [WIDTH-1:0]   sr_data;
  logic               next_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .data_i     (sr_data),
    .next_bit_o (next_bit)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    reps_d    = reps_q;
    data_d    = data_q;
    x_d       = IDLE_LEVEL;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          data_d    = in_data;
          reps_d    = in_reps;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
          sr_load   = 1'b1;
          sr_data   = in_data;
          x_d       = first_bit(in_data);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          if (rep_cnt_q < reps_q) begin
            // Reload straight from the captured word so repeats run with no gap.
            rep_cnt_d = rep_cnt_q + REP_W'(1);
            bit_cnt_d = '0;
            sr_load   = 1'b1;
            x_d       = first_bit(data_q);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d   = ST_DONE;
            bit_cnt_d = '0;
            rep_cnt_d = '0;
            done_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sr_shift  = 1'b1;
          x_d       = next_bit;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      reps_q    <= '0;
      data_q    <= '0;
      x_q       <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      reps_q    <= reps_d;
      data_q    <= data_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
